// File: rtl/hazard_controller.sv
// Load-use hazard and control-flow hazard controller for a 5-stage pipeline.
// Stalls for LOAD_STALLS cycles per load-use hazard; taken branches flush IF/ID.
module hazard_controller #(
  parameter int ADDR_BITS   = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_mem_to_reg,
  input  logic [ADDR_BITS-1:0] ex_rt,
  input  logic [ADDR_BITS-1:0] id_rs,
  input  logic [ADDR_BITS-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 branch_taken,
  output logic                 stall_flag,
  output logic                 reset_control_buses,
  output logic                 flush_if_id,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 fsm_state
);

  localparam logic       IDLE       = 1'b0;
  localparam logic       STALL      = 1'b1;
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALLS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic       state, next_state;
  logic [3:0] remain, next_remain;
  logic       hazard;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_mem_to_reg && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign fsm_state = state;

  always_comb begin
    stall_flag          = 1'b0;
    reset_control_buses = 1'b0;
    flush_if_id         = 1'b0;
    next_state          = state;
    next_remain         = remain;
    if (reset) begin
      next_state  = IDLE;
      next_remain = 4'd0;
    end else if (branch_taken) begin
      // A resolved branch outranks any stall: the stalled instruction is on the wrong path.
      flush_if_id         = 1'b1;
      reset_control_buses = 1'b1;
      next_state          = IDLE;
      next_remain         = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard) begin
            stall_flag          = 1'b1;
            reset_control_buses = 1'b1;
            if (LOAD_STALLS > 1) begin
              next_state  = STALL;
              next_remain = STALL_INIT;
            end
          end
        end
        STALL: begin
          stall_flag          = 1'b1;
          reset_control_buses = 1'b1;
          if (remain <= 4'd1) begin
            next_state  = IDLE;
            next_remain = 4'd0;
          end else begin
            next_remain = remain - 4'd1;
          end
        end
        default: begin
          next_state  = IDLE;
          next_remain = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remain      <= 4'd0;
      stall_count <= '0;
    end else begin
      state  <= next_state;
      remain <= next_remain;
      if (stall_flag && (stall_count != CNT_MAX))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
